block_tx_sequencer: RTL and testbench

Frame-level controller for the plaintext byte-unpacker stage of the Z-modem transmit path. It fetches 128-bit plaintext blocks from the upstream block source (cipher/decrypt output) with a valid/ready handshake and loads each block into the unpacker. It confirms that all 16 bytes of each block complete on the UART TX AXI-Stream before loading the next block, and signals completion of a frame of `num_blocks` blocks.

---
 rtl/block_tx_pkg.sv | 19 +
 rtl/block_tx_sequencer_if.sv | 24 ++
 rtl/tx_wdog.sv | 25 ++
 rtl/block_tx_sequencer.sv | 143 ++++++++++++++
 tb/tb_block_tx_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_tx_pkg.sv
// Shared types and constants for the block TX sequencer: FSM state encoding,
// block geometry and beat counter width.
package block_tx_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLK_W       = BLOCK_BYTES * 8;
  localparam int BEAT_CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/block_tx_sequencer_if.sv
// Block path bundle: upstream block handshake, unpacker load port and the
// UART TX stream monitor taps. The sequencer is the slave side.
interface block_tx_sequencer_if;

  logic [block_tx_pkg::BLK_W-1:0] blk_data;
  logic                           blk_valid;
  logic                           blk_ready;
  logic [block_tx_pkg::BLK_W-1:0] plain_block;
  logic                           load_en;
  logic                           buffer_ready;
  logic                           tx_tvalid;
  logic                           tx_tready;

  modport master (
    output blk_data, blk_valid, buffer_ready, tx_tvalid, tx_tready,
    input  blk_ready, plain_block, load_en
  );

  modport slave (
    input  blk_data, blk_valid, buffer_ready, tx_tvalid, tx_tready,
    output blk_ready, plain_block, load_en
  );

endinterface

// File: rtl/tx_wdog.sv
// Stall watchdog: counts while enabled, clears on request, flags expiry on the
// cycle the count would reach LIMIT.
module tx_wdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign expired = inc && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/block_tx_sequencer.sv
// Frame controller feeding 128-bit blocks to the byte unpacker and confirming
// 16 UART beats per block. Optional stall watchdog: BLOCK_TX_SEQ_WDOG_EN.
module block_tx_sequencer
  import block_tx_pkg::*;
#(
  parameter int NB_W        = 16,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NB_W-1:0]        num_blocks,
  input  logic                   abort,
  block_tx_sequencer_if.slave    bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [NB_W-1:0]        blocks_sent
);

  state_t                state, state_next;
  logic [NB_W-1:0]       num_lat;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  beat, beat_full, last_block, err_next, wdog_expired;
  logic                  accept_start, take_blk, issue_load, drain_exit;

  assign beat       = bus.tx_tvalid & bus.tx_tready;
  assign beat_full  = (beat_cnt == BEAT_CNT_W'(BLOCK_BYTES));
  assign last_block = ((blocks_sent + 1'b1) == num_lat);

`ifdef BLOCK_TX_SEQ_WDOG_EN
  logic wdog_inc, wdog_clr;

  assign wdog_inc = (state == ST_LOAD) || (state == ST_ACK) ||
                    (state == ST_DRAIN) || (state == ST_FLUSH);
  assign wdog_clr = beat || (state_next != state);

  tx_wdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wdog_clr),
    .inc     (wdog_inc),
    .expired (wdog_expired)
  );
`else
  // Watchdog not built: a stall waits until abort.
  assign wdog_expired = (WDOG_CYCLES < 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      ST_IDLE:
        if (start) state_next = (num_blocks == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:
        if (abort) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end else if (bus.blk_valid) state_next = ST_LOAD;
      ST_LOAD:
        if (abort || (!bus.buffer_ready && wdog_expired)) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end else if (bus.buffer_ready) state_next = ST_ACK;
      ST_ACK:
        if (abort) state_next = ST_FLUSH;
        else if (!bus.buffer_ready) state_next = ST_DRAIN;
        else if (wdog_expired) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      ST_DRAIN:
        if (abort) state_next = ST_FLUSH;
        else if (beat_full && bus.buffer_ready) state_next = last_block ? ST_DONE : ST_FETCH;
        else if (wdog_expired) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      ST_FLUSH:
        if (bus.buffer_ready || wdog_expired) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.blk_ready = (state == ST_FETCH);
    accept_start  = (state == ST_IDLE) && start;
    take_blk      = (state == ST_FETCH) && (state_next == ST_LOAD);
    issue_load    = (state == ST_LOAD) && (state_next == ST_ACK);
    drain_exit    = (state == ST_DRAIN) &&
                    ((state_next == ST_FETCH) || ((state_next == ST_DONE) && !err_next));
  end

  // NOTE: the 128-bit block register is reset too, because its reset value is
  // a visible output of the block, not just internal storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.load_en     <= 1'b0;
      bus.plain_block <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      blocks_sent     <= '0;
      num_lat         <= '0;
      beat_cnt        <= '0;
    end else begin
      bus.load_en <= issue_load;
      busy        <= (state_next != ST_IDLE);
      frame_done  <= (state_next == ST_DONE);
      frame_err   <= (state_next == ST_DONE) && err_next;

      if (take_blk) bus.plain_block <= bus.blk_data;

      if (accept_start) begin
        num_lat     <= num_blocks;
        blocks_sent <= '0;
      end else if (drain_exit) begin
        blocks_sent <= blocks_sent + 1'b1;
      end

      // Beats are only attributed to the block in flight; saturation keeps a
      // stray extra beat from wrapping the count.
      if (issue_load) beat_cnt <= '0;
      else if (((state == ST_ACK) || (state == ST_DRAIN)) && beat && !beat_full)
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_block_tx_sequencer.sv
// Self-checking bench for block_tx_sequencer: upstream source, unpacker model
// and block scoreboard, driven by a directed sequence of frame scenarios.
module tb_block_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_blocks = '0;
  logic        abort = 1'b0;
  logic        busy, frame_done, frame_err;
  logic [15:0] blocks_sent;

  int checks = 0;
  int errors = 0;

  block_tx_sequencer_if bus();

  block_tx_sequencer #(.NB_W(16), .WDOG_CYCLES(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_blocks  (num_blocks),
    .abort       (abort),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .blocks_sent (blocks_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] make_block(input int idx);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = 8'(idx * 16 + k);
    return b;
  endfunction

  // Upstream block source
  logic         up_en = 1'b0;
  logic         up_valid = 1'b0;
  logic [127:0] up_data = '0;
  int           up_gap = 0;
  int           gap_cnt = 0;
  int           up_idx = 0;
  bit           hs_prev = 1'b0;
  logic [127:0] exp_q[$];

  assign bus.blk_valid = up_valid;
  assign bus.blk_data  = up_data;

  always @(negedge clk) begin
    if (!reset) begin
      up_valid = 1'b0;
      hs_prev  = 1'b0;
      gap_cnt  = 0;
    end else begin
      if (hs_prev) begin
        up_valid = 1'b0;
        gap_cnt  = up_gap;
      end
      if (gap_cnt > 0) gap_cnt--;
      else if (up_en) begin
        up_valid = 1'b1;
        up_data  = make_block(up_idx);
      end
      hs_prev = up_valid && bus.blk_ready;
      if (hs_prev) begin
        exp_q.push_back(up_data);
        up_idx++;
      end
    end
  end

  // Unpacker model: takes a block on load_en, emits 16 beats, reports idle
  // once the final beat is being presented.
  logic br = 1'b1;
  logic tv = 1'b0;
  logic tr = 1'b1;
  int   beats_left = 0;
  int   load_cnt = 0;
  int   beat_tot = 0;
  int   blk_beat_no = 0;
  int   tr_mode = 1;
  int   tr_cnt = 0;
  bit   beat_pend = 1'b0;
  bit   hold_busy = 1'b0;

  assign bus.buffer_ready = br;
  assign bus.tx_tvalid    = tv;
  assign bus.tx_tready    = tr;

  always @(negedge clk) begin
    if (!reset) begin
      beats_left = 0;
      beat_pend  = 1'b0;
      br         = 1'b1;
      tv         = 1'b0;
    end else begin
      if (beat_pend) begin
        beats_left--;
        beat_tot++;
        blk_beat_no++;
      end
      if (bus.load_en) begin
        load_cnt++;
        check("load_after_16_beats", 128'(beats_left), 128'(0));
        check("sb_nonempty", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) check("block_order", bus.plain_block, exp_q.pop_front());
        beats_left  = 16;
        blk_beat_no = 0;
      end
      tv = (beats_left > 0);
      br = !hold_busy && (beats_left <= 1);
      tr_cnt++;
      case (tr_mode)
        0:       tr = 1'b0;
        1:       tr = 1'b1;
        default: tr = ((tr_cnt / 3) % 2) == 0;
      endcase
      beat_pend = tv && tr;
    end
  end

  task automatic prep();
    exp_q.delete();
    up_idx   = 0;
    load_cnt = 0;
    beat_tot = 0;
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start      = 1'b1;
    num_blocks = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max) begin
      @(negedge clk);
      cyc++;
      seen = frame_done;
    end
  endtask

  task automatic wait_load(input int max, output bit seen);
    int cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < max) begin
      @(negedge clk);
      cyc++;
      seen = bus.load_en;
    end
  endtask

  initial begin
    int cyc;
    bit seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_blk_ready", 128'(bus.blk_ready), 128'(0));
    check("rst_load_en", 128'(bus.load_en), 128'(0));
    check("rst_plain_block", bus.plain_block, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_frame_done", 128'(frame_done), 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
    check("rst_blocks_sent", 128'(blocks_sent), 128'(0));
    reset = 1'b1;
    up_en = 1'b1;

    // Normal 3-block frame
    tr_mode = 1;
    up_gap  = 0;
    prep();
    pulse_start(3);
    check("t1_busy_after_start", 128'(busy), 128'(1));
    check("t1_blk_ready_after_start", 128'(bus.blk_ready), 128'(1));
    wait_done(400, cyc, seen);
    check("t1_done_seen", 128'(seen), 128'(1));
    check("t1_frame_err", 128'(frame_err), 128'(0));
    check("t1_blocks_sent", 128'(blocks_sent), 128'(3));
    check("t1_load_pulses", 128'(load_cnt), 128'(3));
    check("t1_beats", 128'(beat_tot), 128'(48));
    check("t1_sb_drained", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    check("t1_done_one_cycle", 128'(frame_done), 128'(0));
    check("t1_idle_busy", 128'(busy), 128'(0));
    check("t1_sent_held", 128'(blocks_sent), 128'(3));

    // Zero-length frame: DONE directly from IDLE
    prep();
    pulse_start(0);
    check("t2_done", 128'(frame_done), 128'(1));
    check("t2_frame_err", 128'(frame_err), 128'(0));
    check("t2_blocks_sent", 128'(blocks_sent), 128'(0));
    @(negedge clk);
    check("t2_done_one_cycle", 128'(frame_done), 128'(0));
    check("t2_no_load", 128'(load_cnt), 128'(0));

    // Backpressure: tready toggles every 3 cycles, 5-cycle upstream gaps
    tr_mode = 2;
    up_gap  = 5;
    prep();
    pulse_start(2);
    wait_done(800, cyc, seen);
    check("t3_done_seen", 128'(seen), 128'(1));
    check("t3_frame_err", 128'(frame_err), 128'(0));
    check("t3_blocks_sent", 128'(blocks_sent), 128'(2));
    check("t3_load_pulses", 128'(load_cnt), 128'(2));
    check("t3_beats", 128'(beat_tot), 128'(32));

    // Abort after beat 7 of block 2, with the unpacker held busy
    tr_mode = 1;
    up_gap  = 0;
    prep();
    pulse_start(3);
    cyc = 0;
    while (!(load_cnt == 2 && blk_beat_no >= 7) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_reached_beat7", 128'(load_cnt == 2 && blk_beat_no >= 7), 128'(1));
    hold_busy = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    seen  = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("t4_flush_holds", 128'(seen), 128'(0));
    check("t4_flush_busy", 128'(busy), 128'(1));
    hold_busy = 1'b0;
    wait_done(50, cyc, seen);
    check("t4_done_seen", 128'(seen), 128'(1));
    check("t4_frame_err", 128'(frame_err), 128'(1));
    check("t4_blocks_sent", 128'(blocks_sent), 128'(1));

    // Stuck tx_tready
    tr_mode = 0;
    prep();
    pulse_start(1);
    wait_load(50, seen);
    check("t5_load_seen", 128'(seen), 128'(1));
`ifdef BLOCK_TX_SEQ_WDOG_EN
    // ACK->DRAIN one edge after the load pulse, then 64 stalled cycles
    wait_done(200, cyc, seen);
    check("t5_wdog_done_seen", 128'(seen), 128'(1));
    check("t5_wdog_latency", 128'(cyc), 128'(65));
    check("t5_wdog_err", 128'(frame_err), 128'(1));
    check("t5_wdog_sent", 128'(blocks_sent), 128'(0));
    tr_mode = 1;
    repeat (20) @(negedge clk);
`else
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("t5_stall_no_done", 128'(seen), 128'(0));
    check("t5_stall_busy", 128'(busy), 128'(1));
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    tr_mode = 1;
    wait_done(60, cyc, seen);
    check("t5_abort_done_seen", 128'(seen), 128'(1));
    check("t5_abort_err", 128'(frame_err), 128'(1));
    check("t5_abort_sent", 128'(blocks_sent), 128'(0));
`endif

    // Asynchronous reset during DRAIN of block 2
    tr_mode = 1;
    prep();
    pulse_start(3);
    wait_load(50, seen);
    wait_load(50, seen);
    check("t6_second_load", 128'(seen), 128'(1));
    repeat (5) @(negedge clk);
    check("t6_pre_sent", 128'(blocks_sent), 128'(1));
    #2 reset = 1'b0;
    #1;
    check("t6_rst_blk_ready", 128'(bus.blk_ready), 128'(0));
    check("t6_rst_load_en", 128'(bus.load_en), 128'(0));
    check("t6_rst_plain_block", bus.plain_block, 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_frame_done", 128'(frame_done), 128'(0));
    check("t6_rst_frame_err", 128'(frame_err), 128'(0));
    check("t6_rst_blocks_sent", 128'(blocks_sent), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    prep();
    pulse_start(1);
    wait_done(100, cyc, seen);
    check("t6_clean_done_seen", 128'(seen), 128'(1));
    check("t6_clean_err", 128'(frame_err), 128'(0));
    check("t6_clean_sent", 128'(blocks_sent), 128'(1));
    check("t6_clean_loads", 128'(load_cnt), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
